// File: rtl/fp_mul_sched_pkg.sv
// Shared types and defaults for the FP multiplier scheduler: requester-ID tag
// layout and the ID-width helper used to size the round-robin pointer.
package fp_mul_sched_pkg;

  localparam int FP_W            = 32;
  localparam int NUM_REQ_DEF     = 4;
  localparam int MUL_LATENCY_DEF = 2;

  // Tags are sized for the largest supported requester count (8).
  localparam int ID_W_MAX = 3;

  typedef logic [ID_W_MAX-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floatingMultiplierWithRegs.sv
// Fully pipelined IEEE-754 single-precision multiplier, STAGES cycles from
// operand capture to result. Denormals flush to zero; rounding is nearest-even.
module floatingMultiplierWithRegs #(
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        exception
);

  logic [31:0] a_p0, b_p0;
  logic [33:0] prod_c;
  logic [33:0] prod_p1 [STAGES-1];

  function automatic logic [24:0] round_ne(input logic [23:0] mant,
                                           input logic guard, input logic sticky);
    return {1'b0, mant} + ((guard && (sticky || mant[0])) ? 25'd1 : 25'd0);
  endfunction

  // Packed as {exception, overflow, result}.
  function automatic logic [33:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic               sign, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [47:0]        mx, my, prod;
    logic signed [10:0] exp_s;
    logic [23:0]        mant;
    logic [24:0]        mant_r;
    logic               guard, sticky;
    logic [33:0]        res;
    sign   = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    mx     = {24'd0, 1'b1, x[22:0]};
    my     = {24'd0, 1'b1, y[22:0]};
    prod   = mx * my;
    exp_s  = $signed({3'b000, x[30:23]}) + $signed({3'b000, y[30:23]}) - 11'sd127;
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = exp_s + 11'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    mant_r = round_ne(mant, guard, sticky);
    if (mant_r[24]) begin
      exp_s = exp_s + 11'sd1;
      mant  = mant_r[24:1];
    end else begin
      mant  = mant_r[23:0];
    end
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      res = {1'b1, 1'b0, 32'h7FC0_0000};
    else if (x_inf || y_inf)
      res = {1'b1, 1'b0, sign, 8'hFF, 23'd0};
    else if (x_zero || y_zero)
      res = {2'b00, sign, 31'd0};
    else if (exp_s >= 11'sd255)
      res = {1'b0, 1'b1, sign, 8'hFF, 23'd0};
    else if (exp_s <= 11'sd0)
      res = {2'b00, sign, 31'd0};
    else
      res = {2'b00, sign, exp_s[7:0], mant[22:0]};
    return res;
  endfunction

  // p0: operand capture
  always_ff @(posedge clk) begin
    if (en) begin
      a_p0 <= a;
      b_p0 <= b;
    end
  end

  assign prod_c = fp_mul(a_p0, b_p0);

  // p1..: product and delay registers
  always_ff @(posedge clk) begin
    if (en) begin
      prod_p1[0] <= prod_c;
      for (int i = 1; i < STAGES - 1; i++) prod_p1[i] <= prod_p1[i-1];
    end
  end

  assign {exception, overflow, result} = prod_p1[STAGES-2];

endmodule

// File: rtl/fp_mul_rr_arbiter.sv
// Combinational round-robin arbiter: searches from rr_ptr upward, wrapping,
// and grants the first valid requester.
module fp_mul_rr_arbiter
  import fp_mul_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        grant_valid                         = 1'b1;
        grant_id                            = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one pipelined FP multiplier among NUM_REQ requesters: round-robin
// issue, a requester-ID tag that travels alongside the product, one-hot return.
module fp_mul_scheduler
  import fp_mul_sched_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int FP_W        = fp_mul_sched_pkg::FP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]         rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_exception,
  output logic                    busy,
  output logic [15:0]             issued_count
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr, last_id, sel_id, grant_id;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid, transfer;
  logic [FP_W-1:0]    mul_a, mul_b, mul_result;
  logic               mul_overflow, mul_exception;
  tag_t               tag_q [MUL_LATENCY];
  tag_t               tag_out;
  logic               rsp_live;

  fp_mul_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign req_ready = reset ? '0 : grant;
  assign transfer  = grant_valid && !reset;

  // Idle cycles keep feeding the last granted pair; no tag claims those products.
  assign sel_id = grant_valid ? grant_id : last_id;
  assign mul_a  = req_a[int'(sel_id)*FP_W +: FP_W];
  assign mul_b  = req_b[int'(sel_id)*FP_W +: FP_W];

  floatingMultiplierWithRegs #(
    .STAGES (MUL_LATENCY)
  ) u_mul (
    .clk       (clk),
    .en        (1'b1),
    .a         (mul_a),
    .b         (mul_b),
    .result    (mul_result),
    .overflow  (mul_overflow),
    .exception (mul_exception)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      last_id      <= '0;
      issued_count <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      if (transfer) begin
        rr_ptr       <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        last_id      <= grant_id;
        issued_count <= issued_count + 16'd1;
      end
      tag_q[0] <= {transfer, req_id_t'(grant_id)};
      for (int i = 1; i < MUL_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out  = tag_q[MUL_LATENCY-1];
  assign rsp_live = tag_out.valid && !reset;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = rsp_live && (int'(tag_out.id) == i);
    busy = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) busy = busy | tag_q[i].valid;
  end

  assign rsp_result    = rsp_live ? mul_result : '0;
  assign rsp_overflow  = rsp_live && mul_overflow;
  assign rsp_exception = rsp_live && mul_exception;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler: random multi-requester traffic checked every
// cycle against a queue-based reference, plus directed literal scenarios.
module tb_fp_mul_scheduler;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_ready, rsp_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     rsp_result;
  logic             rsp_overflow, rsp_exception, busy;
  logic [15:0]      issued_count;

  always #5 clk = ~clk;

  fp_mul_scheduler #(
    .NUM_REQ     (N),
    .MUL_LATENCY (LAT),
    .FP_W        (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_overflow  (rsp_overflow),
    .rsp_exception (rsp_exception),
    .busy          (busy),
    .issued_count  (issued_count)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Exact product for operands whose significand product fits in 24 bits.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [63:0] p, n;
    int          m, e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    m = 63;
    while (!p[m]) m--;
    e = int'(a[30:23]) + int'(b[30:23]) + m - 173;
    n = p << (47 - m);
    return {s, e[7:0], n[46:24]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    if ($urandom_range(0, 15) == 0)
      v = {1'($urandom_range(0, 1)), 31'd0};
    else
      v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)),
           8'($urandom_range(0, 255)), 15'd0};
    return v;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] res;
    int          due;
  } rsp_t;

  rsp_t         exp_q[$];
  int           cyc = 0;
  int           ptr = 0;
  int           cnt = 0;
  logic [N-1:0] took = '0;

  always @(negedge clk) begin
    logic [N-1:0] er;
    rsp_t         e;
    cyc++;
    if (reset) begin
      chk("ready_in_reset", 64'(req_ready), 64'(0));
      chk("rsp_valid_in_reset", 64'(rsp_valid), 64'(0));
      exp_q.delete();
      ptr  = 0;
      cnt  = 0;
      took = '0;
    end else begin
      er = '0;
      for (int k = 0; k < N; k++)
        if (er == '0 && req_valid[(ptr + k) % N]) er[(ptr + k) % N] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.id);
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_flags", 64'({rsp_overflow, rsp_exception}), 64'(0));
      end else begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
      end
      chk("issued_count", 64'(issued_count), 64'(cnt));
      took = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (took[i]) begin
          exp_q.push_back('{i, fp_model(req_a[i*W +: W], req_b[i*W +: W]), cyc + LAT});
          cnt = (cnt + 1) % 65536;
          ptr = (i + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] sim_a[4];
  logic [31:0] sim_b[4];
  logic [31:0] sim_p[4];

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    sim_a = '{32'h4000_0000, 32'hC144_0000, 32'h3D00_0000, 32'hBF80_0000};
    sim_b = '{32'h4070_0000, 32'hC090_0000, 32'h3F80_0000, 32'hC0E0_0000};
    sim_p = '{32'h40F0_0000, 32'h425C_8000, 32'h3D00_0000, 32'h40E0_0000};

    chk("model_pin_single", 64'(fp_model(32'h40A4_0000, 32'hC0F0_0000)), 64'(32'hC219_C000));
    for (int i = 0; i < 4; i++)
      chk("model_pin_sim", 64'(fp_model(sim_a[i], sim_b[i])), 64'(sim_p[i]));
    chk("model_pin_zero", 64'(fp_model(32'h3D00_0000, 32'h0000_0000)), 64'(0));

    at_neg();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_count", 64'(issued_count), 64'(0));
    chk("reset_rsp_result", 64'(rsp_result), 64'(0));
    tick();
    tick();
    reset = 1'b0;

    // Single requester
    tick();
    req_valid        = 4'b0010;
    req_a[1*W +: W]  = 32'h40A4_0000;
    req_b[1*W +: W]  = 32'hC0F0_0000;
    at_neg();
    chk("single_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    tick();
    at_neg();
    chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("single_rsp_result", 64'(rsp_result), 64'(32'hC219_C000));
    chk("single_rsp_flags", 64'({rsp_overflow, rsp_exception}), 64'(0));

    // Simultaneous requests
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = sim_a[i];
      req_b[i*W +: W] = sim_b[i];
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      if (k < 4) chk("sim_grant", 64'(req_ready), 64'(1) << k);
      if (k >= 2) begin
        chk("sim_rsp_valid", 64'(rsp_valid), 64'(1) << (k - 2));
        chk("sim_rsp_result", 64'(rsp_result), 64'(sim_p[k-2]));
      end
      tick();
      if (k < 4) req_valid[k] = 1'b0;
    end
    at_neg();
    chk("sim_issued_count", 64'(issued_count), 64'(4));

    // Fairness between requesters 0 and 2
    do_reset();
    tick();
    req_a[0*W +: W] = rnd_op();
    req_b[0*W +: W] = rnd_op();
    req_a[2*W +: W] = rnd_op();
    req_b[2*W +: W] = rnd_op();
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("fair_grant", 64'(req_ready), (k % 2 == 0) ? 64'(4'b0001) : 64'(4'b0100));
      tick();
    end
    req_valid = '0;

    // Zero operand
    do_reset();
    tick();
    req_a[0*W +: W] = 32'h3D00_0000;
    req_b[0*W +: W] = 32'h0000_0000;
    req_valid = 4'b0001;
    at_neg();
    tick();
    req_valid = '0;
    tick();
    at_neg();
    chk("zero_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("zero_rsp_result", 64'(rsp_result), 64'(0));

    // Reset one cycle after a grant
    do_reset();
    tick();
    req_a[3*W +: W] = rnd_op();
    req_b[3*W +: W] = rnd_op();
    req_a[1*W +: W] = rnd_op();
    req_b[1*W +: W] = rnd_op();
    req_valid = 4'b1000;
    at_neg();
    chk("midrst_grant", 64'(req_ready), 64'(4'b1000));
    tick();
    reset     = 1'b1;
    req_valid = 4'b1010;
    at_neg();
    chk("midrst_ready_low", 64'(req_ready), 64'(0));
    tick();
    reset = 1'b0;
    at_neg();
    chk("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_count", 64'(issued_count), 64'(0));
    chk("midrst_next_grant", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || took[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            req_valid[i]    = 1'b1;
            req_a[i*W +: W] = rnd_op();
            req_b[i*W +: W] = rnd_op();
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Counter wrap
    do_reset();
    tick();
    req_a[0*W +: W] = rnd_op();
    req_b[0*W +: W] = rnd_op();
    req_valid = 4'b0001;
    repeat (65535) tick();
    at_neg();
    chk("wrap_pre", 64'(issued_count), 64'(16'hFFFF));
    tick();
    req_valid = '0;
    at_neg();
    chk("wrap_zero", 64'(issued_count), 64'(0));
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
